// File: rtl/signal_sequencer.sv
// Plays a small table of {x, y, duration} phases on x/y, optionally repeating the table, then returns to idle.
// Latency: outputs show phase 0 one cycle after an accepted start; a phase with duration d lasts d+1 cycles, with no gaps.
// Backpressure: none; start is ignored while running, stop aborts at the next edge, and table writes are dropped while busy.
module signal_sequencer #(
    parameter int NPH   = 4,
    parameter int AW    = 2,
    parameter int DUR_W = 8,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [DUR_W+1:0] wr_data,
    input  logic [AW:0]      num_phases,
    input  logic [REP_W-1:0] reps,
    input  logic             start,
    input  logic             stop,
    output logic             x,
    output logic             y,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    phase_idx
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [AW:0]      NP_MAX  = (AW+1)'(NPH);
    localparam logic [AW:0]      NP_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]    IDX_ONE = AW'(1);
    localparam logic [DUR_W-1:0] CNT_ONE = DUR_W'(1);
    localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

    logic [DUR_W+1:0] tbl [NPH];

    state_t           state_q, state_d;
    logic [AW:0]      np_q, np_eff;
    logic [REP_W-1:0] rp_q;
    logic [DUR_W-1:0] cnt_q, cnt_d;
    logic [REP_W-1:0] pass_q, pass_d;
    logic             x_d, y_d, busy_d, done_d;
    logic [AW-1:0]    idx_d;

    logic [DUR_W+1:0] cur_ent, nxt_ent, first_ent;
    logic             wr_ok, accept_start;
    logic             last_cycle, last_phase, more_pass;

    assign wr_ok        = (state_q == S_IDLE) && wr_en;
    assign accept_start = (state_q == S_IDLE) && start && !stop;

    // A same-cycle write to entry 0 must be visible to the phase being started.
    assign first_ent = (wr_en && wr_addr == '0) ? wr_data : tbl[0];
    assign cur_ent   = tbl[phase_idx];
    assign nxt_ent   = tbl[phase_idx + IDX_ONE];

    assign last_cycle = (cnt_q == cur_ent[DUR_W-1:0]);
    assign last_phase = ({1'b0, phase_idx} == (np_q - NP_ONE));
    assign more_pass  = (rp_q == '0) || (pass_q < (rp_q - REP_ONE));

    always_comb begin
        np_eff = num_phases;
        if (num_phases == '0) begin
            np_eff = NP_ONE;
        end else if (num_phases > NP_MAX) begin
            np_eff = NP_MAX;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NPH; i++) begin
                tbl[i] <= '0;
            end
        end else if (wr_ok) begin
            tbl[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            np_q      <= NP_ONE;
            rp_q      <= '0;
            cnt_q     <= '0;
            pass_q    <= '0;
            x         <= 1'b0;
            y         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            phase_idx <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pass_q    <= pass_d;
            x         <= x_d;
            y         <= y_d;
            busy      <= busy_d;
            done      <= done_d;
            phase_idx <= idx_d;
            if (accept_start) begin
                np_q <= np_eff;
                rp_q <= reps;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (last_cycle && last_phase && !more_pass) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        x_d    = 1'b0;
        y_d    = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        idx_d  = '0;
        cnt_d  = '0;
        pass_d = pass_q;
        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    x_d    = first_ent[DUR_W+1];
                    y_d    = first_ent[DUR_W];
                    busy_d = 1'b1;
                    pass_d = '0;
                end
            end
            S_RUN: begin
                if (stop) begin
                    pass_d = pass_q;
                end else if (!last_cycle) begin
                    x_d    = cur_ent[DUR_W+1];
                    y_d    = cur_ent[DUR_W];
                    busy_d = 1'b1;
                    idx_d  = phase_idx;
                    cnt_d  = cnt_q + CNT_ONE;
                end else if (!last_phase) begin
                    x_d    = nxt_ent[DUR_W+1];
                    y_d    = nxt_ent[DUR_W];
                    busy_d = 1'b1;
                    idx_d  = phase_idx + IDX_ONE;
                end else if (more_pass) begin
                    // Pass counter saturates; with reps = 0 its value no longer matters.
                    x_d    = tbl[0][DUR_W+1];
                    y_d    = tbl[0][DUR_W];
                    busy_d = 1'b1;
                    pass_d = (pass_q == '1) ? pass_q : pass_q + REP_ONE;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: begin
                pass_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_signal_sequencer.sv
// Randomized scoreboard bench for signal_sequencer: a trace model expands each run into per-cycle expected outputs.
module tb_signal_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = '0;
    logic [9:0] wr_data = '0;
    logic [2:0] num_phases = '0;
    logic [3:0] reps = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       x, y, busy, done;
    logic [1:0] phase_idx;

    signal_sequencer #(.NPH(4), .AW(2), .DUR_W(8), .REP_W(4)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .num_phases(num_phases), .reps(reps), .start(start), .stop(stop),
        .x(x), .y(y), .busy(busy), .done(done), .phase_idx(phase_idx)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       x;
        logic       y;
        logic       busy;
        logic       done;
        logic [1:0] idx;
    } obs_t;

    obs_t       exp_q[$];
    obs_t       mon_e;
    logic [9:0] mtab [4];
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Monitor: one expected record per cycle while the scoreboard holds any.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("trace{x,y,busy,done,idx}", 32'({x, y, busy, done, phase_idx}), 32'(mon_e));
        end
    end

    task automatic push_obs(input logic ox, input logic oy, input logic ob, input logic od, input int oi);
        obs_t o;
        o.x = ox; o.y = oy; o.busy = ob; o.done = od; o.idx = 2'(oi);
        exp_q.push_back(o);
    endtask

    // Expected trace of one run, cycle 1 onward: n records total, the first nb of them busy.
    task automatic gen_trace(input int npin, input int rp, input int stop_cyc, input int limit,
                             output int n, output int nb);
        int np, pass, c, dur;
        bit fin;
        np = (npin == 0) ? 1 : ((npin > 4) ? 4 : npin);
        c = 1; pass = 0; fin = 0; nb = 0;
        while (!fin) begin
            for (int p = 0; p < np && !fin; p++) begin
                dur = int'(mtab[p][7:0]);
                for (int k = 0; k <= dur && !fin; k++) begin
                    if (c > limit) begin
                        fin = 1;
                    end else if (stop_cyc > 0 && c > stop_cyc) begin
                        push_obs(0, 0, 0, 0, 0); c++; fin = 1;
                    end else begin
                        push_obs(mtab[p][9], mtab[p][8], 1, 0, p); nb = c; c++;
                    end
                end
            end
            if (!fin) begin
                pass++;
                if (rp != 0 && pass >= rp) begin
                    if (stop_cyc > 0 && c > stop_cyc) push_obs(0, 0, 0, 0, 0);
                    else push_obs(0, 0, 0, 1, 0);
                    c++;
                    push_obs(0, 0, 0, 0, 0); c++;
                    fin = 1;
                end
            end
        end
        n = c - 1;
    endtask

    task automatic idle_cycles(input int k);
        repeat (k) begin
            push_obs(0, 0, 0, 0, 0);
            @(negedge clk);
        end
    endtask

    task automatic idle_write(input int a, input logic [9:0] d);
        wr_en = 1'b1; wr_addr = 2'(a); wr_data = d;
        mtab[a] = d;
        push_obs(0, 0, 0, 0, 0);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Entered and left at a falling edge; bw drives table writes on every busy cycle.
    task automatic run(input int npin, input int rp, input int stop_cyc, input int limit, input bit bw);
        int n, nb;
        gen_trace(npin, rp, stop_cyc, limit, n, nb);
        num_phases = 3'(npin); reps = 4'(rp); stop = 1'b0; start = 1'b1;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            start = 1'b0;
            stop = (c == stop_cyc) && (c < n);
            if (bw && c <= nb) begin
                wr_en = 1'b1;
                wr_addr = 2'($urandom_range(0, 3));
                wr_data = 10'($urandom);
            end else begin
                wr_en = 1'b0;
            end
        end
        stop = 1'b0; wr_en = 1'b0;
    endtask

    initial begin
        int rp, npr, sc;
        for (int a = 0; a < 4; a++) mtab[a] = '0;
        repeat (3) @(negedge clk);
        chk("in_reset", 32'({x, y, busy, done, phase_idx}), 32'd0);
        reset = 1'b1;
        idle_cycles(10);

        idle_write(0, {2'b10, 8'd2});
        idle_write(1, {2'b01, 8'd1});
        idle_write(2, {2'b11, 8'd0});
        idle_write(3, {2'b00, 8'd3});

        run(3, 1, 0, 2000, 0);
        run(3, 2, 0, 2000, 0);
        run(3, 0, 105, 2000, 0);
        run(3, 0, 4, 2000, 0);

        start = 1'b1; stop = 1'b1;
        idle_cycles(3);
        start = 1'b0; stop = 1'b0;

        run(0, 1, 0, 2000, 0);
        run(2, 1, 0, 2000, 1);
        run(2, 1, 0, 2000, 0);
        run(7, 1, 0, 2000, 0);

        wr_en = 1'b1; wr_addr = 2'd0; wr_data = {2'b01, 8'd1};
        mtab[0] = {2'b01, 8'd1};
        run(1, 1, 0, 2000, 0);

        idle_write(0, {2'b11, 8'hFF});
        run(1, 1, 0, 2000, 0);

        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < 4; a++)
                idle_write(a, {2'($urandom_range(0, 3)), 8'($urandom_range(0, 4))});
            rp = $urandom_range(0, 3);
            npr = $urandom_range(0, 7);
            if (rp == 0) sc = $urandom_range(1, 30);
            else sc = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 25) : 0;
            run(npr, rp, sc, 2000, 1);
        end

        idle_write(0, {2'b10, 8'd2});
        run(3, 0, 0, 3, 0);
        reset = 1'b0;
        #1;
        chk("async_reset_xy", 32'({x, y}), 32'd0);
        chk("async_reset_busy_done", 32'({busy, done}), 32'd0);
        chk("async_reset_idx", 32'(phase_idx), 32'd0);
        for (int a = 0; a < 4; a++) mtab[a] = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        idle_cycles(2);
        run(4, 1, 0, 2000, 0);
        idle_cycles(2);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
